// File: rtl/rv32i_types.sv
// ============================================================================
// Package     : rv32i_types
// Description : Shared types for the memory arbiter: machine word type and
//               the arbiter state encoding, plus the all-bytes enable value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] rv32i_word;

  // Explicit two-bit state codes, kept as plain constants so that legacy
  // code comparing raw state values keeps working.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT_I = ST_GRANT_I,
    GRANT_D = ST_GRANT_D
  } arb_state_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/arb_req_reg.sv
// ============================================================================
// Module      : arb_req_reg
// Description : Latch-and-hold register for the granted memory request.
//               Captures address, write data, byte enable and read/write
//               flags when i_load is high and holds them otherwise.
// Ports       : clk, rst (async, active-low), i_load, i_address, i_wdata,
//               i_byte_enable, i_read, i_write -> o_address, o_wdata,
//               o_byte_enable, o_read, o_write
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_req_reg
  import rv32i_types::*;
#(
  parameter int DATA_W = $bits(rv32i_word)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_address,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_byte_enable,
  input  logic              i_read,
  input  logic              i_write,
  output logic [DATA_W-1:0] o_address,
  output logic [DATA_W-1:0] o_wdata,
  output logic [3:0]        o_byte_enable,
  output logic              o_read,
  output logic              o_write
);

  logic [DATA_W-1:0] r_address;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_byte_enable;
  logic              r_read;
  logic              r_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_address     <= '0;
      r_wdata       <= '0;
      r_byte_enable <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
    end else if (i_load) begin
      r_address     <= i_address;
      r_wdata       <= i_wdata;
      r_byte_enable <= i_byte_enable;
      r_read        <= i_read;
      r_write       <= i_write;
    end
  end

  assign o_address     = r_address;
  assign o_wdata       = r_wdata;
  assign o_byte_enable = r_byte_enable;
  assign o_read        = r_read;
  assign o_write       = r_write;

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (instruction / data) arbiter in front of a
//               single memory port. A request seen in IDLE is latched and
//               presented on mem_* from the next cycle until mem_resp; the
//               arbiter always passes through IDLE between grants.
// Ports       : clk, rst (async, active-low)
//               I-side : i_read, i_address -> i_rdata, i_resp
//               D-side : d_read, d_write, d_byte_enable, d_address, d_wdata
//                        -> d_rdata, d_resp
//               Memory : mem_read, mem_write, mem_byte_enable, mem_address,
//                        mem_wdata <- mem_rdata, mem_resp
// Config      : ARB_ROUND_ROBIN_EN - when defined, simultaneous requests go
//               to the side not granted last; otherwise the D-side wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import rv32i_types::*;
#(
  parameter int DATA_W = $bits(rv32i_word)
) (
  input  logic              clk,
  input  logic              rst,
  // instruction side
  input  logic              i_read,
  input  logic [DATA_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  // data side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [3:0]        d_byte_enable,
  input  logic [DATA_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  // shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byte_enable,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_ready;

  logic              w_i_req;
  logic              w_d_req;
  logic              w_pick_i;
  logic              w_load;
  logic              w_active;

  logic [DATA_W-1:0] w_ld_address;
  logic [DATA_W-1:0] w_ld_wdata;
  logic [3:0]        w_ld_be;
  logic              w_ld_read;
  logic              w_ld_write;

  logic [DATA_W-1:0] w_q_address;
  logic [DATA_W-1:0] w_q_wdata;
  logic [3:0]        w_q_be;
  logic              w_q_read;
  logic              w_q_write;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  // Arbitration is held off for the first edge after reset release so that
  // the earliest possible grant lands on the second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Set when the most recent grant went to the D-side; reset value points
  // at D so the first contested grant goes to the I-side.
  logic r_last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b1;
    end else if (w_load) begin
      r_last_d <= ~w_pick_i;
    end
  end

  assign w_pick_i = w_i_req & (~w_d_req | r_last_d);
`else
  assign w_pick_i = w_i_req & ~w_d_req;
`endif

  assign w_load = (r_state == IDLE) & r_ready & (w_i_req | w_d_req);

  // Request mux for the winner. A simultaneous d_read/d_write is a write.
  // The I-side has no write data, so zero is captured for it.
  always_comb begin
    if (w_pick_i) begin
      w_ld_address = i_address;
      w_ld_wdata   = '0;
      w_ld_be      = BE_ALL;
      w_ld_read    = 1'b1;
      w_ld_write   = 1'b0;
    end else begin
      w_ld_address = d_address;
      w_ld_wdata   = d_wdata;
      w_ld_be      = d_write ? d_byte_enable : BE_ALL;
      w_ld_read    = d_read & ~d_write;
      w_ld_write   = d_write;
    end
  end

  arb_req_reg #(
    .DATA_W (DATA_W)
  ) u_req_reg (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_address     (w_ld_address),
    .i_wdata       (w_ld_wdata),
    .i_byte_enable (w_ld_be),
    .i_read        (w_ld_read),
    .i_write       (w_ld_write),
    .o_address     (w_q_address),
    .o_wdata       (w_q_wdata),
    .o_byte_enable (w_q_be),
    .o_read        (w_q_read),
    .o_write       (w_q_write)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_load) begin
          w_state_nxt = w_pick_i ? GRANT_I : GRANT_D;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_resp) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Command strobes and byte enables are qualified by the grant state;
  // address and data simply show the last latched values.
  assign w_active        = (r_state != IDLE);
  assign mem_read        = w_active & w_q_read;
  assign mem_write       = w_active & w_q_write;
  assign mem_byte_enable = w_active ? w_q_be : 4'b0000;
  assign mem_address     = w_q_address;
  assign mem_wdata       = w_q_wdata;

  assign i_resp  = mem_resp & (r_state == GRANT_I);
  assign d_resp  = mem_resp & (r_state == GRANT_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Directed scenarios plus
//               a randomized run, all compared against a transaction-level
//               reference model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byte_enable;
  logic [31:0] d_address;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byte_enable   (d_byte_enable),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // Reference model: who owns the memory port (0 none, 1 I, 2 D), the
  // transaction presented on it, and arbitration history.
  int          m_owner;
  bit          m_warm;
  bit          m_last_d;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  bit          m_rd;
  bit          m_wr;

  int          n_chk;
  int          n_fail;
  int          resp_log[$];
  logic        obs_ir;
  logic        obs_dr;
  logic [31:0] obs_irdata;
  logic [31:0] obs_drdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_warm   = 1'b0;
    m_last_d = 1'b1;
    m_addr   = '0;
    m_wdata  = '0;
    m_be     = '0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    bit any_i, any_d, pick_i;
    any_i = i_read;
    any_d = d_read | d_write;
    if (!rst) begin
      model_reset();
    end else if (!m_warm) begin
      m_warm = 1'b1;
    end else if (m_owner == 0) begin
      if (any_i || any_d) begin
        if (any_i && any_d) pick_i = RR ? m_last_d : 1'b0;
        else                pick_i = any_i;
        if (pick_i) begin
          m_owner = 1; m_addr = i_address; m_wdata = 32'h0;
          m_be = 4'hF; m_rd = 1'b1; m_wr = 1'b0;
        end else begin
          m_owner = 2; m_addr = d_address; m_wdata = d_wdata;
          m_wr = d_write; m_rd = !d_write;
          m_be = d_write ? d_byte_enable : 4'hF;
        end
        m_last_d = !pick_i;
      end
    end else if (mem_resp) begin
      m_owner = 0;
    end
  endtask

  // One clock cycle: drive at edge+1, compare at edge+3, then cross the edge.
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd,
                      input logic mr, input logic [31:0] mrd);
    bit act;
    i_read = ir; i_address = ia;
    d_read = dr; d_write = dw; d_byte_enable = dbe;
    d_address = da; d_wdata = dwd;
    mem_resp = mr; mem_rdata = mrd;
    #2;
    act = (m_owner != 0);
    chk("mem_read",  mem_read,        act && m_rd);
    chk("mem_write", mem_write,       act && m_wr);
    chk("mem_be",    mem_byte_enable, act ? m_be : 4'h0);
    chk("mem_addr",  mem_address,     m_addr);
    chk("mem_wdata", mem_wdata,       m_wdata);
    chk("i_resp",    i_resp,          mr && m_owner == 1);
    chk("d_resp",    d_resp,          mr && m_owner == 2);
    chk("i_rdata",   i_rdata,         mrd);
    chk("d_rdata",   d_rdata,         mrd);
    obs_ir = i_resp; obs_dr = d_resp;
    obs_irdata = i_rdata; obs_drdata = d_rdata;
    if (i_resp === 1'b1) resp_log.push_back(1);
    if (d_resp === 1'b1) resp_log.push_back(2);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic mr);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, mr, 32'h0);
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    rst = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_byte_enable = '0;
    d_address = '0; d_wdata = '0;
    mem_resp = 1'b0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read",  mem_read, 0);
    chk("rst_write", mem_write, 0);
    chk("rst_be",    mem_byte_enable, 0);
    chk("rst_addr",  mem_address, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_iresp", i_resp, 0);
    chk("rst_dresp", d_resp, 0);
    rst = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    do_reset();

    // Spurious mem_resp in IDLE (also the warm-up edge after reset).
    idle(1'b1);
    chk("t30_iresp", obs_ir, 0);
    chk("t30_dresp", obs_dr, 0);
    idle(1'b1);
    chk("t30_idle_read", mem_read, 0);

    // Simultaneous requests held for three transactions, fresh from reset.
    do_reset();
    resp_log.delete();
    for (int c = 0; c < 40 && resp_log.size() < 3; c++) begin
      step(1'b1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0, (c % 3) == 2, 32'h0);
    end
    chk("t28_count", resp_log.size(), 3);
    if (resp_log.size() == 3) begin
      chk("t28_g0", resp_log[0], RR ? 1 : 2);
      chk("t28_g1", resp_log[1], 2);
      chk("t28_g2", resp_log[2], RR ? 1 : 2);
    end

    // Instruction read.
    step(1'b1, 32'h60, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("t26_read", mem_read, 1);
    chk("t26_addr", mem_address, 32'h60);
    chk("t26_be",   mem_byte_enable, 4'hF);
    idle(1'b0);
    idle(1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("t26_iresp", obs_ir, 1);
    chk("t26_rdata", obs_irdata, 32'hDEADBEEF);
    chk("t26_idle",  mem_read, 0);

    // Data write with partial byte enables, requester drops mid-transaction.
    step(1'b0, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h104, 32'h12345678, 1'b0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("t27_write", mem_write, 1);
    chk("t27_addr",  mem_address, 32'h104);
    chk("t27_wdata", mem_wdata, 32'h12345678);
    chk("t27_be",    mem_byte_enable, 4'b0011);
    idle(1'b1);
    chk("t27_dresp", obs_dr, 1);
    chk("t27_iresp", obs_ir, 0);
    idle(1'b1);
    chk("t27_pulse", obs_dr, 0);

    // Read and write together become a write.
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'b0101, 32'h40, 32'hA5A5_0000, 1'b0, 32'h0);
    chk("t31_write", mem_write, 1);
    chk("t31_read",  mem_read, 0);
    chk("t31_be",    mem_byte_enable, 4'b0101);
    idle(1'b1);

    // Reset in the middle of a D-side read.
    step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0, 1'b0, 32'h0);
    chk("t29_pre_read", mem_read, 1);
    mem_resp = 1'b1;
    rst = 1'b0;
    #1;
    chk("t29_rst_read",  mem_read, 0);
    chk("t29_rst_dresp", d_resp, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1'b1);
    chk("t29_late_dresp", obs_dr, 0);
    chk("t29_late_iresp", obs_ir, 0);
    idle(1'b1);
    chk("t29_after_dresp", obs_dr, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      step(($urandom % 3) == 0, $urandom,
           ($urandom % 3) == 0, ($urandom % 4) == 0, 4'($urandom),
           $urandom, $urandom,
           ($urandom % 3) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
